// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the EX stage: owns HI/LO, models fixed latency
// with a busy countdown, and requests ID stalls for mult/div-class ops.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        id_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi, r_lo, r_p_hi, r_p_lo;

    logic [63:0] w_sprod, w_uprod;
    logic [31:0] w_abs_a, w_abs_b, w_sdvs, w_udvs;
    logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
    logic [31:0] w_n_hi, w_n_lo;
    logic        w_is_div, w_dvz;

    assign w_sprod = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign w_uprod = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_dvz    = (rt_val == 32'd0);
    assign w_abs_a  = rs_val[31] ? -rs_val : rs_val;
    assign w_abs_b  = rt_val[31] ? -rt_val : rt_val;
    assign w_sdvs   = w_dvz ? 32'd1 : w_abs_b;
    assign w_udvs   = w_dvz ? 32'd1 : rt_val;
    assign w_sq_mag = w_abs_a / w_sdvs;
    assign w_sr_mag = w_abs_a % w_sdvs;
    assign w_sq     = (rs_val[31] ^ rt_val[31]) ? -w_sq_mag : w_sq_mag;
    assign w_sr     = rs_val[31] ? -w_sr_mag : w_sr_mag;
    assign w_uq     = rs_val / w_udvs;
    assign w_ur     = rs_val % w_udvs;

    assign w_is_div = (md_op == 3'd2) || (md_op == 3'd3);

    always_comb begin
        w_n_hi = w_sprod[63:32];
        w_n_lo = w_sprod[31:0];
        case (md_op)
            3'd1: begin
                w_n_hi = w_uprod[63:32];
                w_n_lo = w_uprod[31:0];
            end
            3'd2: begin
                w_n_hi = w_dvz ? r_hi : w_sr;
                w_n_lo = w_dvz ? r_lo : w_sq;
            end
            3'd3: begin
                w_n_hi = w_dvz ? r_hi : w_ur;
                w_n_lo = w_dvz ? r_lo : w_uq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_p_hi <= '0;
            r_p_lo <= '0;
        end else if (r_cnt == '0) begin
            if (start) begin
                r_p_hi <= w_n_hi;
                r_p_lo <= w_n_lo;
                r_cnt  <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else begin
                if (mthi) r_hi <= rs_val;
                if (mtlo) r_lo <= rs_val;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_hi <= r_p_hi;
                r_lo <= r_p_lo;
            end
        end
    end

    assign busy     = (r_cnt != '0);
    assign stall_md = id_md & (start | busy);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_rdata = mfhi ? r_hi : (mflo ? r_lo : 32'd0);

endmodule
